// File: rtl/popcount_frame_acc_if.sv
// Beat-in / frame-result-out bundle for popcount_frame_acc.
// The master modport drives beats and consumes results; the slave modport is the accumulator.
interface popcount_frame_acc_if #(
  parameter int unsigned W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_ones;
  logic [3:0]   in_zeroes;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_ones;
  logic [W-1:0] out_zeroes;
  logic [W-1:0] out_bytes;
  logic         out_sat;
  logic         out_err;

  modport master (
    output in_valid, in_ones, in_zeroes, in_last, out_ready,
    input  in_ready, out_valid, out_ones, out_zeroes, out_bytes, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_ones, in_zeroes, in_last, out_ready,
    output in_ready, out_valid, out_ones, out_zeroes, out_bytes, out_sat, out_err
  );
endinterface

// File: rtl/popcount_frame_acc.sv
// Accumulates per-byte ones/zeroes counts over a frame with saturating totals,
// then holds the frame result until the downstream handshake completes.
module popcount_frame_acc #(
  parameter int unsigned W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_frame_acc_if.slave  bus
);

  localparam int unsigned AW = W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] ones_q, ones_d;
  logic [W-1:0] zeroes_q, zeroes_d;
  logic [W-1:0] bytes_q, bytes_d;
  logic         sat_q, sat_d;
  logic         err_q, err_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;

  logic          accept_c;
  logic          beat_err_c;
  logic [AW-1:0] ones_sum_c;
  logic [AW-1:0] zeroes_sum_c;
  logic [AW-1:0] bytes_sum_c;

  // Wide sums: the top bit set means the W-bit total would exceed 2^W-1.
  always_comb begin
    accept_c     = bus.in_valid && in_ready_q;
    beat_err_c   = (5'(bus.in_ones) + 5'(bus.in_zeroes)) != 5'd8;
    ones_sum_c   = {1'b0, ones_q}   + AW'(bus.in_ones);
    zeroes_sum_c = {1'b0, zeroes_q} + AW'(bus.in_zeroes);
    bytes_sum_c  = {1'b0, bytes_q}  + AW'(1);
  end

  // Next-state, accumulator and handshake-flag logic.
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    zeroes_d = zeroes_q;
    bytes_d  = bytes_q;
    sat_d    = sat_q;
    err_d    = err_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept_c) begin
          ones_d   = ones_sum_c[W]   ? {W{1'b1}} : ones_sum_c[W-1:0];
          zeroes_d = zeroes_sum_c[W] ? {W{1'b1}} : zeroes_sum_c[W-1:0];
          bytes_d  = bytes_sum_c[W]  ? {W{1'b1}} : bytes_sum_c[W-1:0];
          sat_d    = sat_q | ones_sum_c[W] | zeroes_sum_c[W] | bytes_sum_c[W];
          err_d    = err_q | beat_err_c;
          state_d  = bus.in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d  = IDLE;
          ones_d   = '0;
          zeroes_d = '0;
          bytes_d  = '0;
          sat_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ones_q      <= '0;
      zeroes_q    <= '0;
      bytes_q     <= '0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      zeroes_q    <= zeroes_d;
      bytes_q     <= bytes_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_ones   = ones_q;
  assign bus.out_zeroes = zeroes_q;
  assign bus.out_bytes  = bytes_q;
  assign bus.out_sat    = sat_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Directed testbench for popcount_frame_acc: per-scenario tasks with hand-computed totals.
module tb_popcount_frame_acc;

  localparam int unsigned W = 12;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  popcount_frame_acc_if #(.W(W)) bus ();

  popcount_frame_acc #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One accepted beat (caller guarantees in_ready), then in_valid drops.
  task automatic beat(input logic [3:0] o, input logic [3:0] z, input logic l);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_ones   = o;
    bus.in_zeroes = z;
    bus.in_last   = l;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_ones = '0; bus.in_zeroes = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err}
        !== {1'b0, 1'b1, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got v=%b rdy=%b ones=%0d zeroes=%0d bytes=%0d sat=%b err=%b, want v=0 rdy=1 all zero",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err);
    end
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reset_first_cycle: got v=%b rdy=%b, want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    beat(4'd3, 4'd5, 1'b0);
    beat(4'd8, 4'd0, 1'b0);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes}
        !== {1'b0, 1'b1, 12'd11, 12'd5, 12'd2}) begin
      fails++;
      $display("FAIL basic_running: got v=%b rdy=%b ones=%0d zeroes=%0d bytes=%0d, want v=0 rdy=1 ones=11 zeroes=5 bytes=2",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes);
    end
    beat(4'd0, 4'd8, 1'b1);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err}
        !== {1'b1, 1'b0, 12'd11, 12'd13, 12'd3, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL basic_result: got v=%b rdy=%b ones=%0d zeroes=%0d bytes=%0d sat=%b err=%b, want v=1 rdy=0 ones=11 zeroes=13 bytes=3 sat=0 err=0",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err);
    end
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_bytes} !== {1'b0, 1'b1, 12'd0, 12'd0}) begin
      fails++;
      $display("FAIL basic_release: got v=%b rdy=%b ones=%0d bytes=%0d, want v=0 rdy=1 ones=0 bytes=0",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_bytes);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    beat(4'd4, 4'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      // Junk offered while holding must be ignored.
      bus.in_valid = 1'b1; bus.in_ones = 4'd8; bus.in_zeroes = 4'd8; bus.in_last = 1'b1;
      tests++;
      if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_err}
          !== {1'b1, 1'b0, 12'd4, 12'd4, 12'd1, 1'b0}) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got v=%b rdy=%b ones=%0d zeroes=%0d bytes=%0d err=%b, want v=1 rdy=0 ones=4 zeroes=4 bytes=1 err=0",
                 i, bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_err);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes}
        !== {1'b0, 1'b1, 12'd0, 12'd0, 12'd0}) begin
      fails++;
      $display("FAIL hold_release: got v=%b rdy=%b ones=%0d zeroes=%0d bytes=%0d, want v=0 rdy=1 all zero",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 511; i++) beat(4'd8, 4'd0, 1'b0);
    @(negedge clk);
    tests++;
    if ({bus.out_ones, bus.out_bytes, bus.out_sat} !== {12'd4088, 12'd511, 1'b0}) begin
      fails++;
      $display("FAIL sat_before: got ones=%0d bytes=%0d sat=%b, want ones=4088 bytes=511 sat=0",
               bus.out_ones, bus.out_bytes, bus.out_sat);
    end
    beat(4'd8, 4'd0, 1'b1);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err}
        !== {1'b1, 12'd4095, 12'd0, 12'd512, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL sat_result: got v=%b ones=%0d zeroes=%0d bytes=%0d sat=%b err=%b, want v=1 ones=4095 zeroes=0 bytes=512 sat=1 err=0",
               bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_sat, bus.out_ones} !== {1'b0, 1'b0, 12'd0}) begin
      fails++;
      $display("FAIL sat_clear: got v=%b sat=%b ones=%0d, want v=0 sat=0 ones=0", bus.out_valid, bus.out_sat, bus.out_ones);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_err();
    bus.out_ready = 1'b1;
    beat(4'd5, 4'd5, 1'b0);
    beat(4'd2, 4'd6, 1'b1);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err}
        !== {1'b1, 12'd7, 12'd11, 12'd2, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL err_frame: got v=%b ones=%0d zeroes=%0d bytes=%0d sat=%b err=%b, want v=1 ones=7 zeroes=11 bytes=2 sat=0 err=1",
               bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err);
    end
    beat(4'd1, 4'd7, 1'b1);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_err}
        !== {1'b1, 12'd1, 12'd7, 12'd1, 1'b0}) begin
      fails++;
      $display("FAIL err_next_clean: got v=%b ones=%0d zeroes=%0d bytes=%0d err=%b, want v=1 ones=1 zeroes=7 bytes=1 err=0",
               bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_err);
    end
    beat(4'd12, 4'd9, 1'b1);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_err}
        !== {1'b1, 12'd12, 12'd9, 12'd1, 1'b1}) begin
      fails++;
      $display("FAIL err_over8: got v=%b ones=%0d zeroes=%0d bytes=%0d err=%b, want v=1 ones=12 zeroes=9 bytes=1 err=1",
               bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_err);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    beat(4'd7, 4'd1, 1'b0);
    beat(4'd7, 4'd1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes}
        !== {1'b0, 1'b1, 12'd0, 12'd0, 12'd0}) begin
      fails++;
      $display("FAIL midrst_cleared: got v=%b rdy=%b ones=%0d zeroes=%0d bytes=%0d, want v=0 rdy=1 all zero",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_zeroes, bus.out_bytes);
    end
    beat(4'd6, 4'd2, 1'b1);
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err}
        !== {1'b1, 12'd6, 12'd2, 12'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midrst_frame: got v=%b ones=%0d zeroes=%0d bytes=%0d sat=%b err=%b, want v=1 ones=6 zeroes=2 bytes=1 sat=0 err=0",
               bus.out_valid, bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err);
    end
    // Reset while holding, with a beat offered at the same edge.
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_ones = 4'd3; bus.in_zeroes = 4'd5; bus.in_last = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_ones, bus.out_bytes} !== {1'b0, 1'b1, 12'd0, 12'd0}) begin
      fails++;
      $display("FAIL holdrst_discard: got v=%b rdy=%b ones=%0d bytes=%0d, want v=0 rdy=1 ones=0 bytes=0",
               bus.out_valid, bus.in_ready, bus.out_ones, bus.out_bytes);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ob [6] = '{4'd1, 4'd2, 4'd8, 4'd4, 4'd0, 4'd7};
    logic [3:0] zb [6] = '{4'd7, 4'd6, 4'd0, 4'd4, 4'd8, 4'd1};
    logic       lb [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3*W+1:0] exp_res [3];
    logic [3*W+1:0] got_res [3];
    int idx = 0;
    int nf  = 0;
    logic acc;
    exp_res[0] = {12'd3, 12'd13, 12'd2, 1'b0, 1'b0};
    exp_res[1] = {12'd8, 12'd0, 12'd1, 1'b0, 1'b0};
    exp_res[2] = {12'd11, 12'd13, 12'd3, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nf < 3; cyc++) begin
      @(negedge clk);
      if (idx < 6) begin
        bus.in_valid = 1'b1; bus.in_ones = ob[idx]; bus.in_zeroes = zb[idx]; bus.in_last = lb[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        tests++;
        if (bus.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ready_in_hold: got rdy=%b, want 0", bus.in_ready);
        end
        got_res[nf] = {bus.out_ones, bus.out_zeroes, bus.out_bytes, bus.out_sat, bus.out_err};
        nf++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (nf != 3) begin
      fails++;
      $display("FAIL b2b_timeout: got %0d frames, want 3", nf);
    end
    for (int f = 0; f < nf; f++) begin
      tests++;
      if (got_res[f] !== exp_res[f]) begin
        fails++;
        $display("FAIL b2b_frame%0d: got ones=%0d zeroes=%0d bytes=%0d sat=%b err=%b, want ones=%0d zeroes=%0d bytes=%0d sat=0 err=0",
                 f, got_res[f][3*W+1:2*W+2], got_res[f][2*W+1:W+2], got_res[f][W+1:2], got_res[f][1], got_res[f][0],
                 exp_res[f][3*W+1:2*W+2], exp_res[f][2*W+1:W+2], exp_res[f][W+1:2]);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_saturation();
    test_err();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
